animated_sprite_bitmap: RTL and testbench
=========================================

# animated_sprite_bitmap

Parametrised multi-frame sprite renderer for the VGA object layer. It converts a pixel offset inside an object's bounding rectangle into an 8-bit RGB value, a drawing request and a 4-bit edge-hit code. It adds frame animation sequenced on the VGA frame pulse, integer scaling, and tear-free horizontal/vertical mirroring. It sits between the square/rectangle position block and the object mux.

## Interface
- WIDTH_BITS, 5: log2 of source bitmap width in pixels.
- HEIGHT_BITS, 5: log2 of source bitmap height in pixels.
- FRAMES, 4: number of animation frames, 1..16.
- SCALE_SHIFT, 0: each source pixel is drawn as a 2^SCALE_SHIFT square on screen.
- DWELL, 6: VGA frames each animation frame is shown, 1..255.
- LOOP, 1: 1 = wrap after the last frame; 0 = stop on the last frame.
- HIT_GRID_BITS, 2: hit grid is 2^HIT_GRID_BITS by 2^HIT_GRID_BITS cells.
- clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-high.
- startOfFrame, input, 1: one-cycle pulse at the VGA frame start.
- offsetX, input, 11: X offset from the rectangle's top-left corner.
- offsetY, input, 11: Y offset from the rectangle's top-left corner.
- InsideRectangle, input, 1: the pixel is inside the bounding rectangle.
- play, input, 1: level; start or resume the animation.
- stop, input, 1: level; return to IDLE at frame 0.
- mirrorX, input, 1: mirror left-right.
- mirrorY, input, 1: mirror top-bottom.
- drawingRequest, output, 1: the pixel is opaque.
- RGBout, output, 8: pixel colour.
- HitEdgeCode, output, 4: {Left, Top, Right, Bottom}.
- frameIndex, output, 4: frame currently displayed.
- animDone, output, 1: one-cycle pulse when a non-loop sequence completes.

## Operation
**Animation FSM**
- States are IDLE, PLAY and DONE.
- IDLE: frameIndex = 0 and dwell counter = 0. If play=1 and stop=0, go to PLAY.
- PLAY: the dwell counter increments only on startOfFrame. On startOfFrame with counter = DWELL-1:
  - counter clears;
  - if frameIndex < FRAMES-1, frameIndex increments;
  - otherwise, with LOOP=1, frameIndex wraps to 0;
  - otherwise, with LOOP=0, go to DONE and pulse animDone for one cycle.
- play=0 in PLAY freezes the dwell counter (pause) and the state stays PLAY.
- DONE: hold the last frame. A rising edge on play restarts at frame 0 and goes to PLAY.
- stop=1 in any state forces IDLE on the next clock. If stop and play are both 1, stop wins.
- FRAMES=1: frameIndex stays 0. With LOOP=0, the first dwell expiry still pulses animDone.

**Mirror latching**
- mirrorX and mirrorY are sampled only on startOfFrame, so a change never tears mid-frame.

**Pixel path**
- sx = offsetX >> SCALE_SHIFT, sy = offsetY >> SCALE_SHIFT.
- If sx or sy is at or beyond the bitmap size, the pixel is treated as outside.
- When the latched mirror bit is set, the address uses (W-1-sx) and/or (H-1-sy).

**Hit code**
- Computed from the unmirrored sx and sy, i.e. in screen orientation.
- cell = coordinate >> (bits - HIT_GRID_BITS).
- Left = (cellX==0), Right = (cellX==max), Top = (cellY==0), Bottom = (cellY==max). Corner cells set two bits.
- HitEdgeCode is 0 when the pixel is outside.

**Outputs**
- Outside pixels give RGBout = TRANSPARENT_ENCODING (8'hFF).
- drawingRequest = (RGBout != 8'hFF). It is derived from the registered RGBout, so it adds no latency.

## Timing
- Pixel latency is 2 clocks.
  - Stage 1 registers the address, the inside flag and the hit code.
  - Stage 2 is the registered ROM read, driving RGBout and HitEdgeCode.
- A frameIndex change takes effect on the clock after startOfFrame, then on pixel outputs 2 clocks later.
- Reset values:
  - RGBout = 8'hFF, drawingRequest = 0, HitEdgeCode = 0.
  - frameIndex = 0, animDone = 0.
  - State = IDLE, dwell counter = 0, latched mirrors = 0.
  - Pipeline valid flags = 0.
- Reset asserted mid-animation returns to the reset values on the next clock. No partial frame advance occurs.
- The dwell counter is 8 bits wide and is compared against DWELL-1, so it never wraps past DWELL-1.

## Structure
- Package sprite_pkg holds:
  - anim_state_t enum {IDLE, PLAY, DONE};
  - TRANSPARENT_ENCODING;
  - HIT_LEFT, HIT_TOP, HIT_RIGHT, HIT_BOTTOM bit-index constants.
- Sub-module sprite_frame_rom:
  - FRAMES × 2^HEIGHT_BITS × 2^WIDTH_BITS × 8-bit constant array;
  - registered read with address {frame, y, x};
  - provides stage 2.
- The top level contains the FSM, mirror latches, scaling, hit logic and stage 1.

## Test plan
- Reset with defaults, InsideRectangle=1, offset (0,0) → after 2 clocks RGBout = ROM[0][0][0], and HitEdgeCode = 4'b1100 (Left and Top).
- play=1, DWELL=6, FRAMES=4, LOOP=1, 30 startOfFrame pulses → frameIndex steps 0,1,2,3,0 every 6 pulses, and animDone stays 0.
- LOOP=0, same stimulus → frameIndex holds 3 after 24 pulses; animDone pulses once; a play rising edge restarts at 0.
- mirrorX toggled mid-frame, offset (0,5) → output unchanged until the next startOfFrame, then equals ROM[f][5][31]. HitEdgeCode stays Left.
- SCALE_SHIFT=1, offset (64,0) → RGBout = 8'hFF and drawingRequest = 0. Offset (3,3) reads source pixel (1,1).
- stop and play both high in PLAY → IDLE with frameIndex = 0 next clock. Reset mid-PLAY → all reset values.

Source files
------------

// File: rtl/animated_sprite_bitmap_pkg.sv
// Shared types and constants for the animated sprite renderer.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} anim_state_t;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  // Bit positions inside HitEdgeCode = {Left, Top, Right, Bottom}
  localparam int unsigned HIT_LEFT   = 3;
  localparam int unsigned HIT_TOP    = 2;
  localparam int unsigned HIT_RIGHT  = 1;
  localparam int unsigned HIT_BOTTOM = 0;

endpackage

// File: rtl/animated_sprite_bitmap_if.sv
// Pixel-side bus between the rectangle position block and the sprite renderer.
interface animated_sprite_bitmap_if;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic [3:0]  HitEdgeCode;

  modport master (
    output offsetX, offsetY, InsideRectangle,
    input  drawingRequest, RGBout, HitEdgeCode
  );

  modport slave (
    input  offsetX, offsetY, InsideRectangle,
    output drawingRequest, RGBout, HitEdgeCode
  );
endinterface

// File: rtl/animated_sprite_bitmap_rom.sv
// Multi-frame sprite bitmap with registered read; second pixel pipeline stage.
module sprite_frame_rom
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = 5,
  parameter int unsigned HEIGHT_BITS = 5,
  parameter int unsigned FRAMES      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [3:0]             frame,
  input  logic [HEIGHT_BITS-1:0] y,
  input  logic [WIDTH_BITS-1:0]  x,
  input  logic [3:0]             hit_in,
  output logic [7:0]             rgb,
  output logic [3:0]             hit
);
  localparam int unsigned DEPTH = FRAMES << (WIDTH_BITS + HEIGHT_BITS);
  localparam int unsigned AW    = $clog2(DEPTH);

  function automatic logic [7:0] pixel_at(int unsigned i);
    int unsigned f, py, px;
    f  = i >> (WIDTH_BITS + HEIGHT_BITS);
    py = (i >> WIDTH_BITS) & ((1 << HEIGHT_BITS) - 1);
    px = i & ((1 << WIDTH_BITS) - 1);
    return 8'(f * 77 + py * 13 + px * 3);
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] addr;

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = pixel_at(i);
  end

  // Truncation drops unused high frame bits of {frame, y, x}
  assign addr = AW'({frame, y, x});

  always_ff @(posedge clk) begin
    if (reset || !valid) begin
      rgb <= TRANSPARENT_ENCODING;
      hit <= '0;
    end else begin
      rgb <= mem[addr];
      hit <= hit_in;
    end
  end
endmodule

// File: rtl/animated_sprite_bitmap.sv
// Animated, scaled, mirrorable sprite renderer: animation FSM plus pixel stage 1.
module animated_sprite_bitmap
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH_BITS    = 5,
  parameter int unsigned HEIGHT_BITS   = 5,
  parameter int unsigned FRAMES        = 4,
  parameter int unsigned SCALE_SHIFT   = 0,
  parameter int unsigned DWELL         = 6,
  parameter int unsigned LOOP          = 1,
  parameter int unsigned HIT_GRID_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     play,
  input  logic                     stop,
  input  logic                     mirrorX,
  input  logic                     mirrorY,
  animated_sprite_bitmap_if.slave  pix,
  output logic [3:0]               frameIndex,
  output logic                     animDone
);
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] FRAME_LAST = 4'(FRAMES - 1);

  anim_state_t state_q, state_d;
  logic [3:0]  frame_q, frame_d;
  logic [7:0]  dwell_q, dwell_d;
  logic        done_d, play_q;
  logic        mx_q, my_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      dwell_q  <= '0;
      animDone <= 1'b0;
      play_q   <= 1'b0;
      mx_q     <= 1'b0;
      my_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      dwell_q  <= dwell_d;
      animDone <= done_d;
      play_q   <= play;
      if (startOfFrame) begin
        mx_q <= mirrorX;
        my_q <= mirrorY;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      frame_d = '0;
      dwell_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          frame_d = '0;
          dwell_d = '0;
          if (play) state_d = PLAY;
        end
        PLAY: begin
          if (play && startOfFrame) begin
            if (dwell_q == DWELL_LAST) begin
              dwell_d = '0;
              if (frame_q < FRAME_LAST) frame_d = frame_q + 4'd1;
              else if (LOOP != 0)       frame_d = '0;
              else begin
                state_d = DONE;
                done_d  = 1'b1;
              end
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end
        end
        DONE: begin
          if (play && !play_q) begin
            state_d = PLAY;
            frame_d = '0;
            dwell_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign frameIndex = frame_q;

  logic [10:0]              sx, sy;
  logic [WIDTH_BITS-1:0]    bx, ax;
  logic [HEIGHT_BITS-1:0]   by, ay;
  logic [HIT_GRID_BITS-1:0] cx, cy;
  logic [3:0]               hit_c;
  logic                     inside_c;

  assign sx = pix.offsetX >> SCALE_SHIFT;
  assign sy = pix.offsetY >> SCALE_SHIFT;
  assign inside_c = pix.InsideRectangle && ((sx >> WIDTH_BITS) == '0)
                    && ((sy >> HEIGHT_BITS) == '0);
  assign bx = sx[WIDTH_BITS-1:0];
  assign by = sy[HEIGHT_BITS-1:0];
  // W-1-sx is a bitwise invert because the bitmap size is a power of two
  assign ax = mx_q ? ~bx : bx;
  assign ay = my_q ? ~by : by;
  assign cx = bx[WIDTH_BITS-1 -: HIT_GRID_BITS];
  assign cy = by[HEIGHT_BITS-1 -: HIT_GRID_BITS];

  always_comb begin
    hit_c             = '0;
    hit_c[HIT_LEFT]   = (cx == '0);
    hit_c[HIT_TOP]    = (cy == '0);
    hit_c[HIT_RIGHT]  = (cx == '1);
    hit_c[HIT_BOTTOM] = (cy == '1);
  end

  logic                   s1_valid;
  logic [3:0]             s1_frame, s1_hit;
  logic [WIDTH_BITS-1:0]  s1_x;
  logic [HEIGHT_BITS-1:0] s1_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_frame <= '0;
      s1_hit   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= inside_c;
      s1_frame <= frame_q;
      s1_hit   <= inside_c ? hit_c : '0;
      s1_x     <= ax;
      s1_y     <= ay;
    end
  end

  sprite_frame_rom #(
    .WIDTH_BITS (WIDTH_BITS),
    .HEIGHT_BITS(HEIGHT_BITS),
    .FRAMES     (FRAMES)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .valid (s1_valid),
    .frame (s1_frame),
    .y     (s1_y),
    .x     (s1_x),
    .hit_in(s1_hit),
    .rgb   (pix.RGBout),
    .hit   (pix.HitEdgeCode)
  );

  assign pix.drawingRequest = (pix.RGBout != TRANSPARENT_ENCODING);
endmodule

// File: tb/tb_animated_sprite_bitmap.sv
// Bench for animated_sprite_bitmap: three parameterisations against a behavioural model.
module tb_animated_sprite_bitmap;
  logic        clk = 1'b0;
  logic        rst, sof, ply, stp, mirx, miry, ins;
  logic [10:0] offx, offy;
  logic [3:0]  fi0, fi1, fi2;
  logic        ad0, ad1, ad2;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  animated_sprite_bitmap_if if0();
  animated_sprite_bitmap_if if1();
  animated_sprite_bitmap_if if2();

  assign if0.offsetX = offx;  assign if0.offsetY = offy;  assign if0.InsideRectangle = ins;
  assign if1.offsetX = offx;  assign if1.offsetY = offy;  assign if1.InsideRectangle = ins;
  assign if2.offsetX = offx;  assign if2.offsetY = offy;  assign if2.InsideRectangle = ins;

  animated_sprite_bitmap #(.WIDTH_BITS(5), .HEIGHT_BITS(5), .FRAMES(4), .SCALE_SHIFT(0),
    .DWELL(6), .LOOP(1), .HIT_GRID_BITS(2)) u_dut0 (
    .clk(clk), .reset(rst), .startOfFrame(sof), .play(ply), .stop(stp),
    .mirrorX(mirx), .mirrorY(miry), .pix(if0.slave), .frameIndex(fi0), .animDone(ad0));

  animated_sprite_bitmap #(.WIDTH_BITS(5), .HEIGHT_BITS(5), .FRAMES(4), .SCALE_SHIFT(0),
    .DWELL(6), .LOOP(0), .HIT_GRID_BITS(2)) u_dut1 (
    .clk(clk), .reset(rst), .startOfFrame(sof), .play(ply), .stop(stp),
    .mirrorX(mirx), .mirrorY(miry), .pix(if1.slave), .frameIndex(fi1), .animDone(ad1));

  animated_sprite_bitmap #(.WIDTH_BITS(5), .HEIGHT_BITS(5), .FRAMES(4), .SCALE_SHIFT(1),
    .DWELL(6), .LOOP(1), .HIT_GRID_BITS(2)) u_dut2 (
    .clk(clk), .reset(rst), .startOfFrame(sof), .play(ply), .stop(stp),
    .mirrorX(mirx), .mirrorY(miry), .pix(if2.slave), .frameIndex(fi2), .animDone(ad2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] rom_val(int f, int y, int x);
    return 8'(f * 77 + y * 13 + x * 3);
  endfunction

  function automatic int scale_of(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic bit loops(int i);
    return (i != 1);
  endfunction

  // Model: playing/finished flags, shown frame, start-of-frame count in current frame
  bit         m_playing[3], m_finished[3], m_prev_play[3], m_done[3], m_mx[3], m_my[3];
  int         m_frame[3], m_sofs[3];
  logic [7:0] e1_rgb[3], eo_rgb[3];
  logic [3:0] e1_hit[3], eo_hit[3];

  always @(posedge clk) begin : model
    int sxv, syv, ax, ay;
    for (int i = 0; i < 3; i++) begin
      eo_rgb[i] = e1_rgb[i];
      eo_hit[i] = e1_hit[i];
      sxv = int'(offx) >> scale_of(i);
      syv = int'(offy) >> scale_of(i);
      if (ins && sxv < 32 && syv < 32) begin
        ax = m_mx[i] ? 31 - sxv : sxv;
        ay = m_my[i] ? 31 - syv : syv;
        e1_rgb[i] = rom_val(m_frame[i], ay, ax);
        e1_hit[i] = {sxv / 8 == 0, syv / 8 == 0, sxv / 8 == 3, syv / 8 == 3};
      end else begin
        e1_rgb[i] = 8'hFF;
        e1_hit[i] = 4'h0;
      end
      m_done[i] = 1'b0;
      if (rst || stp) begin
        m_playing[i] = 1'b0; m_finished[i] = 1'b0; m_frame[i] = 0; m_sofs[i] = 0;
      end else if (m_finished[i]) begin
        if (ply && !m_prev_play[i]) begin
          m_finished[i] = 1'b0; m_playing[i] = 1'b1; m_frame[i] = 0; m_sofs[i] = 0;
        end
      end else if (!m_playing[i]) begin
        if (ply) m_playing[i] = 1'b1;
      end else if (ply && sof) begin
        m_sofs[i]++;
        if (m_sofs[i] == 6) begin
          m_sofs[i] = 0;
          if (m_frame[i] < 3) m_frame[i]++;
          else if (loops(i)) m_frame[i] = 0;
          else begin
            m_playing[i] = 1'b0; m_finished[i] = 1'b1; m_done[i] = 1'b1;
          end
        end
      end
      m_prev_play[i] = rst ? 1'b0 : ply;
      if (rst) begin
        m_mx[i] = 1'b0; m_my[i] = 1'b0;
        e1_rgb[i] = 8'hFF; e1_hit[i] = 4'h0; eo_rgb[i] = 8'hFF; eo_hit[i] = 4'h0;
      end else if (sof) begin
        m_mx[i] = mirx; m_my[i] = miry;
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rgb0",   if0.RGBout, eo_rgb[0]);
      chk("dreq0",  if0.drawingRequest, eo_rgb[0] != 8'hFF);
      chk("hit0",   if0.HitEdgeCode, eo_hit[0]);
      chk("frame0", fi0, m_frame[0]);
      chk("done0",  ad0, m_done[0]);
      chk("rgb1",   if1.RGBout, eo_rgb[1]);
      chk("dreq1",  if1.drawingRequest, eo_rgb[1] != 8'hFF);
      chk("hit1",   if1.HitEdgeCode, eo_hit[1]);
      chk("frame1", fi1, m_frame[1]);
      chk("done1",  ad1, m_done[1]);
      chk("rgb2",   if2.RGBout, eo_rgb[2]);
      chk("dreq2",  if2.drawingRequest, eo_rgb[2] != 8'hFF);
      chk("hit2",   if2.HitEdgeCode, eo_hit[2]);
      chk("frame2", fi2, m_frame[2]);
      chk("done2",  ad2, m_done[2]);
    end
  end

  initial begin
    int nd;
    rst = 1'b1; sof = 1'b0; ply = 1'b0; stp = 1'b0; mirx = 1'b0; miry = 1'b0;
    ins = 1'b1; offx = '0; offy = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick(); tick();
    chk("lit_origin_rgb", if0.RGBout, 8'h00);
    chk("lit_origin_hit", if0.HitEdgeCode, 4'b1100);
    chk("lit_origin_dreq", if0.drawingRequest, 1'b1);

    ply = 1'b1; tick();
    nd = 0;
    for (int k = 1; k <= 30; k++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      chk("lit_loop_frame", fi0, (k / 6) % 4);
      chk("lit_loop_nodone", ad0, 1'b0);
      chk("lit_once_frame", fi1, (k < 24) ? k / 6 : 3);
      if (ad1 === 1'b1) nd++;
      tick();
    end
    chk("lit_once_done_count", nd, 1);
    ply = 1'b0; tick();
    ply = 1'b1; tick();
    chk("lit_restart_frame", fi1, 0);
    ply = 1'b0;

    offx = 11'd0; offy = 11'd5;
    tick(); tick();
    chk("lit_unmirrored", if0.RGBout, 8'h8E);
    mirx = 1'b1;
    tick(); tick(); tick();
    chk("lit_mirror_held", if0.RGBout, 8'h8E);
    sof = 1'b1; tick(); sof = 1'b0;
    tick(); tick();
    chk("lit_mirrored", if0.RGBout, 8'hEB);
    chk("lit_mirrored_hit", if0.HitEdgeCode, 4'b1100);

    mirx = 1'b0; sof = 1'b1; tick(); sof = 1'b0;
    offx = 11'd64; offy = 11'd0;
    tick(); tick();
    chk("lit_scale_out_rgb", if2.RGBout, 8'hFF);
    chk("lit_scale_out_dreq", if2.drawingRequest, 1'b0);
    offx = 11'd3; offy = 11'd3;
    tick(); tick();
    chk("lit_scale_in_rgb", if2.RGBout, 8'h5D);
    chk("lit_scale_in_dreq", if2.drawingRequest, 1'b1);

    ply = 1'b1; stp = 1'b1; tick();
    chk("lit_stop_frame", fi0, 0);
    stp = 1'b0; tick();
    for (int k = 0; k < 7; k++) begin
      sof = 1'b1; tick(); sof = 1'b0; tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("lit_rst_frame", fi0, 0);
    chk("lit_rst_done", ad0, 1'b0);
    chk("lit_rst_rgb", if0.RGBout, 8'hFF);
    chk("lit_rst_dreq", if0.drawingRequest, 1'b0);
    chk("lit_rst_hit", if0.HitEdgeCode, 4'h0);

    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 999) == 0);
      stp  = ($urandom_range(0, 299) == 0);
      ply  = ($urandom_range(0, 19) != 0);
      sof  = ($urandom_range(0, 5) == 0);
      mirx = 1'($urandom_range(0, 1));
      miry = 1'($urandom_range(0, 1));
      ins  = ($urandom_range(0, 7) != 0);
      offx = 11'($urandom_range(0, 75));
      offy = 11'($urandom_range(0, 75));
      tick();
    end
    rst = 1'b0; stp = 1'b0; sof = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
